// File: rtl/am2905_fifo_xcvr.sv
// FIFO-buffered successor to the Am2905 bus transceiver: driver FIFO onto an inverted
// open-collector bus, receiver FIFO onto a tri-state R port. Optional parity: AM2905_PARITY_EN.
module am2905_fifo_xcvr #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             cp,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             dld_,
   input  logic             be_,
   input  logic             dadv_,
   inout  tri   [WIDTH-1:0] bus_,
   input  logic             rle_,
   input  logic             rrd_,
   input  logic             oe_,
   output tri   [WIDTH-1:0] r,
   output logic             dempty,
   output logic             dfull,
   output logic             rempty,
   output logic             rfull,
`ifdef AM2905_PARITY_EN
   inout  tri               bpar_,
   output logic             perr,
`endif
   output logic             dovf,
   output logic             rovf
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] dmem_q [DEPTH];
   logic [WIDTH-1:0] rmem_q [DEPTH];
   logic [PW-1:0]    dwp_q, dwp_d, drp_q, drp_d, rwp_q, rwp_d, rrp_q, rrp_d;
   logic [CW-1:0]    dcnt_q, dcnt_d, rcnt_q, rcnt_d;
   logic             dempty_q, dempty_d, dfull_q, dfull_d, dovf_q, dovf_d;
   logic             rempty_q, rempty_d, rfull_q, rfull_d, rovf_q, rovf_d;
   logic             d_push, d_pop, r_push, r_pop, bus_drv;
   logic [WIDTH-1:0] d_din, d_head, r_din;

   assign d_din   = sel ? b : a;
   assign d_head  = dmem_q[drp_q];
   assign bus_drv = !be_ && !dempty_q;
   // Released lines rely on external pull-ups, so a released bit captures as logic 0.
   assign r_din   = ~bus_;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bus
      assign bus_[i] = (bus_drv && d_head[i]) ? 1'b0 : 1'bz;
   end

   assign r = oe_ ? {WIDTH{1'bz}} : rmem_q[rrp_q];

   always_comb begin
      d_pop    = !dadv_ && (dcnt_q != '0);
      d_push   = !dld_ && ((dcnt_q != CW'(DEPTH)) || d_pop);
      dovf_d   = dovf_q | (!dld_ && !d_push);
      dwp_d    = d_push ? dwp_q + PW'(1) : dwp_q;
      drp_d    = d_pop ? drp_q + PW'(1) : drp_q;
      dcnt_d   = dcnt_q + {{PW{1'b0}}, d_push} - {{PW{1'b0}}, d_pop};
      dempty_d = (dcnt_d == '0);
      dfull_d  = (dcnt_d == CW'(DEPTH));

      r_pop    = !rrd_ && (rcnt_q != '0);
      r_push   = !rle_ && ((rcnt_q != CW'(DEPTH)) || r_pop);
      rovf_d   = rovf_q | (!rle_ && !r_push);
      rwp_d    = r_push ? rwp_q + PW'(1) : rwp_q;
      rrp_d    = r_pop ? rrp_q + PW'(1) : rrp_q;
      rcnt_d   = rcnt_q + {{PW{1'b0}}, r_push} - {{PW{1'b0}}, r_pop};
      rempty_d = (rcnt_d == '0);
      rfull_d  = (rcnt_d == CW'(DEPTH));
   end

   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         dwp_q    <= '0;
         drp_q    <= '0;
         dcnt_q   <= '0;
         dempty_q <= 1'b1;
         dfull_q  <= 1'b0;
         dovf_q   <= 1'b0;
         rwp_q    <= '0;
         rrp_q    <= '0;
         rcnt_q   <= '0;
         rempty_q <= 1'b1;
         rfull_q  <= 1'b0;
         rovf_q   <= 1'b0;
      end else begin
         dwp_q    <= dwp_d;
         drp_q    <= drp_d;
         dcnt_q   <= dcnt_d;
         dempty_q <= dempty_d;
         dfull_q  <= dfull_d;
         dovf_q   <= dovf_d;
         rwp_q    <= rwp_d;
         rrp_q    <= rrp_d;
         rcnt_q   <= rcnt_d;
         rempty_q <= rempty_d;
         rfull_q  <= rfull_d;
         rovf_q   <= rovf_d;
      end
   end

   // Storage has no reset; contents are only visible through the pointers.
   always_ff @(posedge cp) begin
      if (d_push) dmem_q[dwp_q] <= d_din;
      if (r_push) rmem_q[rwp_q] <= r_din;
   end

   assign dempty = dempty_q;
   assign dfull  = dfull_q;
   assign dovf   = dovf_q;
   assign rempty = rempty_q;
   assign rfull  = rfull_q;
   assign rovf   = rovf_q;

`ifdef AM2905_PARITY_EN
   logic perr_q, perr_d;

   assign bpar_ = (bus_drv && (^d_head)) ? 1'b0 : 1'bz;

   always_comb begin
      perr_d = perr_q | (!rle_ && ((^r_din) != !bpar_));
   end

   always_ff @(posedge cp or posedge rst) begin
      if (rst) perr_q <= 1'b0;
      else     perr_q <= perr_d;
   end

   assign perr = perr_q;
`endif

endmodule

// File: tb/tb_am2905_fifo_xcvr.sv
// Directed bench for am2905_fifo_xcvr (WIDTH=4, DEPTH=4); parity steps run under AM2905_PARITY_EN.
module tb_am2905_fifo_xcvr;

   logic       cp = 1'b0;
   logic       rst;
   logic [3:0] a, b;
   logic       sel, dld_, be_, dadv_, rle_, rrd_, oe_;
   tri   [3:0] bus_;
   tri   [3:0] r;
   logic       dempty, dfull, rempty, rfull, dovf, rovf;
   logic       tb_drv_en;
   logic [3:0] tb_drv;
   int         tests = 0;
   int         fails = 0;

   // Pull-ups: any released line (bus or R) reads back as 1.
   pullup (bus_[0]);
   pullup (bus_[1]);
   pullup (bus_[2]);
   pullup (bus_[3]);
   pullup (r[0]);
   pullup (r[1]);
   pullup (r[2]);
   pullup (r[3]);

   assign bus_ = tb_drv_en ? tb_drv : 4'bzzzz;

`ifdef AM2905_PARITY_EN
   tri   bpar_;
   logic perr;
   logic tb_par_en, tb_par;
   pullup (bpar_);
   assign bpar_ = tb_par_en ? tb_par : 1'bz;
`endif

   am2905_fifo_xcvr #(.WIDTH(4), .DEPTH(4)) dut (
      .cp     (cp),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sel    (sel),
      .dld_   (dld_),
      .be_    (be_),
      .dadv_  (dadv_),
      .bus_   (bus_),
      .rle_   (rle_),
      .rrd_   (rrd_),
      .oe_    (oe_),
      .r      (r),
      .dempty (dempty),
      .dfull  (dfull),
      .rempty (rempty),
      .rfull  (rfull),
`ifdef AM2905_PARITY_EN
      .bpar_  (bpar_),
      .perr   (perr),
`endif
      .dovf   (dovf),
      .rovf   (rovf)
   );

   always #5 cp = ~cp;

   task automatic tick();
      @(posedge cp);
      #2;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic idle();
      dld_ = 1'b1; dadv_ = 1'b1; rle_ = 1'b1; rrd_ = 1'b1;
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; sel = 1'b0;
      dld_ = 1'b1; be_ = 1'b1; dadv_ = 1'b1; rle_ = 1'b1; rrd_ = 1'b1; oe_ = 1'b1;
      tb_drv_en = 1'b0; tb_drv = '0;
`ifdef AM2905_PARITY_EN
      tb_par_en = 1'b0; tb_par = 1'b0;
`endif
      #12;
      chk("rst_dempty", {3'b0, dempty}, 4'b0001);
      chk("rst_rempty", {3'b0, rempty}, 4'b0001);
      chk("rst_flags", {dfull, rfull, dovf, rovf}, 4'b0000);
      chk("rst_bus", bus_, 4'b1111);
      rst = 1'b0;

      // Fill driver FIFO: A=0000, A=1111, B=0101, B=1010
      dld_ = 1'b0; sel = 1'b0; a = 4'b0000; tick();
      chk("push1_dempty", {3'b0, dempty}, 4'b0000);
      a = 4'b1111; tick();
      sel = 1'b1; b = 4'b0101; tick();
      b = 4'b1010; tick();
      chk("fill_dfull", {3'b0, dfull}, 4'b0001);

      // Fifth push while full is dropped
      sel = 1'b0; a = 4'b0011; tick();
      idle();
      chk("ovf_dovf", {3'b0, dovf}, 4'b0001);
      chk("ovf_dfull", {3'b0, dfull}, 4'b0001);
      be_ = 1'b0; #1;
      chk("bus_head0000", bus_, 4'b1111);

      dadv_ = 1'b0; tick();
      chk("bus_head1111", bus_, 4'b0000);
      chk("pop1_dfull", {3'b0, dfull}, 4'b0000);
      tick();
      chk("bus_head0101", bus_, 4'b1010);
      tick();
      dadv_ = 1'b1;
      chk("bus_head1010", bus_, 4'b0101);

      // Loopback + simultaneous driver push/pop at count 1
      rle_ = 1'b0; dadv_ = 1'b0; dld_ = 1'b0; sel = 1'b0; a = 4'b0110; tick();
      idle();
      chk("lb_rempty", {3'b0, rempty}, 4'b0000);
      chk("lb_dcount1", {2'b0, dempty, dfull}, 4'b0000);
      chk("lb_new_head", bus_, 4'b1001);
      oe_ = 1'b0; #1;
      chk("lb_r", r, 4'b1010);
      oe_ = 1'b1;

      // Last pop empties driver and releases bus
      dadv_ = 1'b0; tick();
      dadv_ = 1'b1;
      chk("drain_dempty", {3'b0, dempty}, 4'b0001);
      chk("drain_bus", bus_, 4'b1111);

      // Push+pop while empty: pop ignored, push lands
      dld_ = 1'b0; dadv_ = 1'b0; a = 4'b0001; tick();
      idle();
      chk("emptypp_dempty", {3'b0, dempty}, 4'b0000);
      chk("emptypp_bus", bus_, 4'b1110);
      be_ = 1'b1;

      // Empty the receiver, then receive bench-driven words
      rrd_ = 1'b0; tick();
      rrd_ = 1'b1;
      chk("rx_drain_rempty", {3'b0, rempty}, 4'b0001);
      #1;
      tb_drv_en = 1'b1; tb_drv = 4'b1100; rle_ = 1'b0; tick();
      tb_drv = 4'b0011; tick();
      rle_ = 1'b1; tb_drv_en = 1'b0;
      chk("rx_rempty", {3'b0, rempty}, 4'b0000);
      oe_ = 1'b0; #1;
      chk("rx_r_first", r, 4'b0011);
      rrd_ = 1'b0; tick();
      rrd_ = 1'b1;
      chk("rx_r_second", r, 4'b1100);
      oe_ = 1'b1; #1;
      chk("rx_r_released", r, 4'b1111);

      // Fill receiver: captures 1110, 1101, 1011
      tb_drv_en = 1'b1; rle_ = 1'b0;
      tb_drv = 4'b0001; tick();
      tb_drv = 4'b0010; tick();
      tb_drv = 4'b0100; tick();
      chk("rx_rfull", {3'b0, rfull}, 4'b0001);
      tb_drv = 4'b0111; rrd_ = 1'b0; tick();
      rrd_ = 1'b1;
      chk("rx_pp_full_rovf", {2'b0, rfull, rovf}, 4'b0010);
      oe_ = 1'b0; #1;
      chk("rx_pp_head", r, 4'b1110);
      tb_drv = 4'b0110; tick();
      rle_ = 1'b1; tb_drv_en = 1'b0;
      chk("rx_ovf_rovf", {3'b0, rovf}, 4'b0001);
      chk("rx_ovf_head", r, 4'b1110);
      oe_ = 1'b1;

      // Async reset with entries queued and bus driven
      dld_ = 1'b0; a = 4'b0010; tick();
      dld_ = 1'b1;
      be_ = 1'b0; #1;
      chk("pre_rst_bus", bus_, 4'b1110);
      #2; rst = 1'b1; #1;
      chk("mid_rst_empty", {2'b0, dempty, rempty}, 4'b0011);
      chk("mid_rst_flags", {dfull, rfull, dovf, rovf}, 4'b0000);
      chk("mid_rst_bus", bus_, 4'b1111);
      be_ = 1'b1;
      #4; rst = 1'b0;

`ifdef AM2905_PARITY_EN
      tick();
      dld_ = 1'b0; a = 4'b0111; tick();
      dld_ = 1'b1; be_ = 1'b0; #1;
      chk("par_bpar_odd", {3'b0, bpar_}, 4'b0000);
      chk("par_perr_clear", {3'b0, perr}, 4'b0000);
      be_ = 1'b1; #1;
      tb_drv_en = 1'b1; tb_drv = 4'b1000; tb_par_en = 1'b1; tb_par = 1'b1; rle_ = 1'b0; tick();
      rle_ = 1'b1; tb_drv_en = 1'b0; tb_par_en = 1'b0;
      chk("par_perr_set", {3'b0, perr}, 4'b0001);
      oe_ = 1'b0; #1;
      chk("par_word_stored", r, 4'b0111);
      oe_ = 1'b1;
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/am2905_fifo_xcvr.md
Name: am2905_fifo_xcvr

Overview:
- Parametrised successor to the Am2905 bus transceiver.
- Driver side: a DEPTH-entry FIFO loaded from A or B (SEL), replacing the single driver register.
- Bus side: inverting, open-collector transfer on the shared active-low bus.
- Receiver side: a clocked DEPTH-entry FIFO, replacing the transparent latch, feeding a tri-state R port.
- Sits between a CPU-side datapath and a wired-AND system bus; decouples producer, bus and consumer timing.

Parameters:
- WIDTH, 4, data width of A, B, bus_ and R.
- DEPTH, 4, entries per FIFO; power of two, >= 2.

Ports:
- cp  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  source A.
- b  input  WIDTH  source B.
- sel  input  1  0 = A, 1 = B, for driver push.
- dld_  input  1  active-low driver push.
- be_  input  1  active-low bus enable.
- dadv_  input  1  active-low driver pop (transfer done).
- bus_  inout  WIDTH  open-collector, inverted bus.
- rle_  input  1  active-low receiver capture.
- rrd_  input  1  active-low receiver pop.
- oe_  input  1  active-low R output enable.
- r  output  WIDTH  receiver head, tri-state.
- dempty, dfull, rempty, rfull  output  1  FIFO flags.
- dovf, rovf  output  1  sticky overflow flags.

Behaviour:
- Reset (async, rst=1): both FIFOs empty; pointers and counts 0; dempty=rempty=1; dfull=rfull=0; dovf=rovf=0; bus_ all z.
  - Storage contents are don't-care.
  - r follows oe_ as usual; with receiver empty it shows storage, which is don't-care.
  - Reset asserted mid-operation aborts any transfer immediately.
- Driver push: on cp rise with dld_=0 and (not dfull, or pop in the same cycle), (sel ? b : a) is written at the tail.
  - Push while full without a pop is dropped and sets dovf.
- Bus drive: combinational. When be_=0 and not dempty, bus_[i]=0 where head[i]=1, else z. In all other cases bus_ is all z. The device never drives 1.
- Driver pop: on cp rise with dadv_=0 and not dempty.
  - Pop when empty is ignored with no flag.
  - Simultaneous push+pop: count unchanged; legal when full and when empty.
  - Empty case: the pop is ignored, the push lands, count becomes 1.
- Receiver capture: on cp rise with rle_=0, ~bus_ is pushed. A z/1 bus bit reads as logic 0; the bench supplies pull-ups.
  - Full without a pop: word dropped, rovf set.
  - The device's own drive is captured too (loopback), as in the Am2905.
- Receiver pop: on cp rise with rrd_=0 and not rempty. Simultaneous push/pop rules match the driver FIFO.
- R output: oe_=0 gives r = receiver head (unregistered, updates the cycle after a pop/push); oe_=1 gives r = z.
- Flags: registered from counts; valid the cycle after any change.
  - dfull/rfull = (count==DEPTH); dempty/rempty = (count==0).
- Pointers are log2(DEPTH) bits, wrapping modulo DEPTH; counts are log2(DEPTH)+1 bits.
- dovf/rovf clear only on rst.

Optional Feature:
- Macro: AM2905_PARITY_EN.
- Defined:
  - Adds inout bpar_ (1-bit open-collector) and output perr (sticky).
  - bpar_ is driven 0 when the bus is driven and the driver head has odd parity.
  - On receive capture, the computed parity of ~bus_ is compared with ~bpar_; a mismatch sets perr, cleared by rst.
  - The captured word is still stored.
- Undefined: bpar_ and perr are absent; no parity logic.

Test Plan:
- Reset: rst=1 mid-stream with 2 entries queued -> dempty=rempty=1, dfull=rfull=0, dovf=rovf=0, bus_=zzzz immediately.
- Driver fill/drain (WIDTH=4, DEPTH=4): push A=0000, A=1111, B=0101, B=1010 -> dfull=1.
  - be_=0 -> bus_=1111; each dadv_ cycle steps bus_ to 0000, 1010, 0101; the fourth pop -> dempty=1, bus_=zzzz.
- Overflow: fifth push 0011 while full, no pop -> dropped, dovf=1; head is still 0000.
- Receive: bench drives bus_=1100 then 0011 with rle_=0 -> rempty=0; oe_=0 -> r=0011.
  - Assert rrd_ -> r=1100; oe_=1 -> r=zzzz.
- Loopback and simultaneous: be_=0 with head 1010, rle_=0, dadv_=0, dld_=0 in one cycle -> receiver gets 1010, driver count unchanged.
  - Push into full rx with rrd_=0 -> accepted, rovf stays 0.
- Parity (AM2905_PARITY_EN): drive head 0111 -> bpar_=0.
  - Bench forces bpar_=1 on receive of 0111 -> perr=1, word stored.
